ir_command_sequencer: RTL and testbench
=======================================

IR_COMMAND_SEQUENCER -- requirements
Module: ir_command_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h91, first of three consecutive bus addresses (STAGE=BASE, PUSH=BASE+1, CTRL=BASE+2).
REQ-002 SHALL have parameter TICK_COUNT, default 10_000_000, CLK cycles per 100 ms duration tick.
REQ-003 SHALL have parameter DEPTH, default 8, command FIFO entries (power of two).
REQ-004 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port BUS_ADDR  input  8  processor bus address.
REQ-007 SHALL have port BUS_DATA  inout  8  processor bus data.
REQ-008 SHALL have port BUS_WE  input  1  bus write enable.
REQ-009 SHALL have port IR_CMD  output  8  {car select[7:4], direction[3:0]} byte to the IR transmitter.
REQ-010 SHALL have port IR_CMD_WE  output  1  one-cycle strobe qualifying IR_CMD.
REQ-011 SHALL have port BUS_INTERRUPT_RAISE  output  1  queue-drained interrupt.
REQ-012 SHALL have port BUS_INTERRUPT_ACK  input  1  interrupt acknowledge.

Function
REQ-013 SHALL latch BUS_DATA into an 8-bit staging register on BUS_WE at STAGE.
REQ-014 SHALL, on BUS_WE at PUSH, push {staging, BUS_DATA} into the FIFO; duration 0 is stored as 1.
REQ-015 SHALL accept a push when count<DEPTH or a pop occurs in the same cycle; otherwise drop it and set sticky OVF.
REQ-016 SHALL, on BUS_WE at CTRL: bit0=1 flushes; bit1=1 clears OVF; both may act in one write.
REQ-017 SHALL drive BUS_DATA with {OVF, BUSY, FULL, EMPTY, count[3:0]} while BUS_ADDR==CTRL and BUS_WE=0, high-Z otherwise.
REQ-018 SHALL implement FSM IDLE/HOLD: IDLE with FIFO non-empty pops, registers IR_CMD, pulses IR_CMD_WE, loads duration, goes HOLD.
REQ-019 SHALL restart the tick prescaler on every load so consecutive IR_CMD_WE pulses are exactly duration*TICK_COUNT cycles apart.
REQ-020 SHALL, at HOLD expiry, pop and emit the next entry in the same cycle if non-empty, else emit IR_CMD=8'h00 with IR_CMD_WE and go IDLE.
REQ-021 SHALL produce IR_CMD_WE two cycles after a push edge that finds the FSM IDLE and FIFO empty.
REQ-022 SHALL, on flush, empty the FIFO, emit 8'h00 with IR_CMD_WE the next cycle if BUSY, go IDLE; a same-cycle push is discarded.
REQ-023 SHALL report BUSY=1 exactly while in HOLD.
REQ-024 SHALL wrap FIFO pointers modulo DEPTH; count is DEPTH-width+1 bits.

Reset
REQ-025 SHALL, on RESET=0 at a clock edge, set IR_CMD=8'h00, IR_CMD_WE=0, BUS_INTERRUPT_RAISE=0, OVF=0, staging=0, FIFO empty, FSM IDLE, prescaler 0.
REQ-026 SHALL abort any HOLD on reset without emitting a neutral strobe.

Configuration
REQ-027 SHALL, with IR_SEQ_IRQ_EN defined, set BUS_INTERRUPT_RAISE when the FSM enters IDLE via HOLD expiry and clear it on BUS_INTERRUPT_ACK (ack wins if simultaneous).
REQ-028 SHALL, without IR_SEQ_IRQ_EN, tie BUS_INTERRUPT_RAISE to 0 and ignore BUS_INTERRUPT_ACK.

Structure
REQ-029 SHALL take register offsets, NEUTRAL_CMD=8'h00, status bit positions and the FSM state enum from shared package ir_pkg.
REQ-030 SHALL place storage in one sub-module ir_seq_fifo (synchronous push/pop, count, full/empty).

Verification
REQ-031 Bench (TICK_COUNT=4): STAGE=8'h12, PUSH=3 -> IR_CMD_WE with 8'h12 two cycles later, then 8'h00 strobe 12 cycles after.
REQ-032 Push 8'h14/2 then 8'h18/1 -> strobes 8'h14, 8'h18 (8 cycles later), 8'h00 (4 cycles later); BUSY low after.
REQ-033 Nine pushes while HOLD blocks pops -> ninth dropped, status reads FULL=1, OVF=1, count=8; CTRL=8'h02 clears OVF.
REQ-034 Flush mid-HOLD with 3 queued -> 8'h00 strobe next cycle, status 8'h10 (EMPTY only).
REQ-035 RESET low mid-HOLD -> IR_CMD=8'h00, no strobe, status 8'h10; with IR_SEQ_IRQ_EN, drain raises IRQ, ACK clears it.
REQ-036 PUSH with duration 0 -> behaves as duration 1 (strobe gap TICK_COUNT cycles).

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg: register map offsets, neutral command, status bit layout and FSM states
// shared by the IR command sequencer and its FIFO.
package ir_pkg;
  localparam logic [7:0] STAGE_OFS = 8'd0;
  localparam logic [7:0] PUSH_OFS = 8'd1;
  localparam logic [7:0] CTRL_OFS = 8'd2;
  localparam logic [7:0] NEUTRAL_CMD = 8'h00;
  localparam int ST_OVF = 7;
  localparam int ST_BUSY = 6;
  localparam int ST_FULL = 5;
  localparam int ST_EMPTY = 4;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR_OVF = 1;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic logic [7:0] pack_status(input logic ovf, input logic busy, input logic full,
                                             input logic empty, input logic [3:0] cnt);
    logic [7:0] s;
    s = {4'b0, cnt};
    s[ST_OVF] = ovf;
    s[ST_BUSY] = busy;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    return s;
  endfunction
endpackage

// File: rtl/ir_seq_fifo.sv
// ir_seq_fifo: show-ahead command FIFO with synchronous push/pop/flush, occupancy count and full/empty flags.
module ir_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rd_data = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/ir_command_sequencer.sv
// ir_command_sequencer: bus-loaded queue of {car/direction, duration} entries replayed to the IR transmitter.
// Define IR_SEQ_IRQ_EN to raise BUS_INTERRUPT_RAISE when the queue drains at the end of a hold.
module ir_command_sequencer
  import ir_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h91,
  parameter int TICK_COUNT = 10_000_000,
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic [7:0] IR_CMD,
  output logic       IR_CMD_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);
  localparam int PW = TICK_COUNT > 1 ? $clog2(TICK_COUNT) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_COUNT - 1);
  state_t state, state_n;
  logic [7:0] staging, rem, rem_n, cmd_n, dur;
  logic [PW-1:0] presc, presc_n;
  logic we_n, ovf, wr_stage, wr_push, wr_ctrl, flush, push, pop, tick, expire, full, empty;
  logic [CW-1:0] count;
  logic [15:0] head;
  assign wr_stage = BUS_WE && BUS_ADDR == BASE_ADDR + STAGE_OFS;
  assign wr_push = BUS_WE && BUS_ADDR == BASE_ADDR + PUSH_OFS;
  assign wr_ctrl = BUS_WE && BUS_ADDR == BASE_ADDR + CTRL_OFS;
  assign flush = wr_ctrl && BUS_DATA[CTRL_FLUSH];
  assign dur = BUS_DATA == 8'd0 ? 8'd1 : BUS_DATA;
  assign tick = presc == TICK_LAST;
  assign expire = state == HOLD && tick && rem == 8'd1;
  assign pop = !flush && !empty && (state == IDLE || expire);
  assign push = wr_push && (!full || pop);
  assign BUS_DATA = (BUS_ADDR == BASE_ADDR + CTRL_OFS && !BUS_WE) ?
                    pack_status(ovf, state == HOLD, full, empty, 4'(count)) : 8'bz;
  ir_seq_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk(CLK),
    .rst_n(RESET),
    .flush(flush),
    .push(push),
    .pop(pop),
    .wr_data({staging, dur}),
    .rd_data(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // Priority: flush, then load of the next entry, then hold countdown.
  always_comb begin
    state_n = state;
    cmd_n = IR_CMD;
    we_n = 1'b0;
    rem_n = rem;
    presc_n = presc;
    if (flush) begin
      state_n = IDLE;
      presc_n = '0;
      cmd_n = state == HOLD ? NEUTRAL_CMD : IR_CMD;
      we_n = state == HOLD;
    end else if (pop) begin
      state_n = HOLD;
      cmd_n = head[15:8];
      we_n = 1'b1;
      rem_n = head[7:0];
      presc_n = '0;
    end else if (expire) begin
      state_n = IDLE;
      cmd_n = NEUTRAL_CMD;
      we_n = 1'b1;
    end else if (state == HOLD) begin
      presc_n = tick ? '0 : presc + PW'(1);
      rem_n = tick ? rem - 8'd1 : rem;
    end
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      state <= IDLE;
      IR_CMD <= NEUTRAL_CMD;
      IR_CMD_WE <= 1'b0;
      rem <= '0;
      presc <= '0;
      staging <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      IR_CMD <= cmd_n;
      IR_CMD_WE <= we_n;
      rem <= rem_n;
      presc <= presc_n;
      if (wr_stage) staging <= BUS_DATA;
      if (wr_push && !push) ovf <= 1'b1;
      else if (wr_ctrl && BUS_DATA[CTRL_CLR_OVF]) ovf <= 1'b0;
    end
`ifdef IR_SEQ_IRQ_EN
  logic irq;
  assign BUS_INTERRUPT_RAISE = irq;
  always_ff @(posedge CLK)
    if (!RESET || BUS_INTERRUPT_ACK) irq <= 1'b0;
    else if (expire && !pop && !flush) irq <= 1'b1;
`else
  logic unused_ack;
  assign unused_ack = BUS_INTERRUPT_ACK;
  assign BUS_INTERRUPT_RAISE = 1'b0;
`endif
endmodule

// File: tb/tb_ir_command_sequencer.sv
// tb_ir_command_sequencer: table-driven and scoreboarded checks of strobe timing, queueing, overflow, flush and reset.
module tb_ir_command_sequencer;
  localparam logic [7:0] STAGE = 8'h91;
  localparam logic [7:0] PUSH = 8'h92;
  localparam logic [7:0] CTRL = 8'h93;
  logic clk = 1'b0, reset = 1'b0, we = 1'b0, drv_en = 1'b0, ack = 1'b0;
  logic [7:0] addr = 8'h00, drv_val = 8'h00, ir_cmd;
  logic ir_we, irq;
  wire [7:0] bus_data;
  int cyc = 0, n_cmp = 0, n_bad = 0, t, t0;
  typedef struct {int cyc; logic [7:0] cmd;} exp_t;
  typedef struct {logic [7:0] cmd; logic [7:0] dur; int gap;} vec_t;
  exp_t sb[$];
  vec_t vecs[4];
  assign bus_data = drv_en ? drv_val : 8'bz;
  ir_command_sequencer #(.BASE_ADDR(8'h91), .TICK_COUNT(4), .DEPTH(8)) dut (
    .CLK(clk),
    .RESET(reset),
    .BUS_ADDR(addr),
    .BUS_DATA(bus_data),
    .BUS_WE(we),
    .IR_CMD(ir_cmd),
    .IR_CMD_WE(ir_we),
    .BUS_INTERRUPT_RAISE(irq),
    .BUS_INTERRUPT_ACK(ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (ir_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got cmd %h at cycle %0d, expected none", ir_cmd, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cmd", ir_cmd, e.cmd);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic wr(input logic [7:0] a, input logic [7:0] d, output int when);
    addr = a;
    drv_val = d;
    drv_en = 1'b1;
    we = 1'b1;
    when = cyc;
    @(negedge clk);
    we = 1'b0;
    drv_en = 1'b0;
    addr = 8'h00;
  endtask
  task automatic status(input string name, input logic [7:0] exp);
    addr = CTRL;
    #1;
    check(name, bus_data, exp);
    addr = 8'h00;
    @(negedge clk);
  endtask
  task automatic irq_expect(input string name, input logic e);
`ifdef IR_SEQ_IRQ_EN
    check(name, irq, e);
    if (e) begin
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check({name, "_ack"}, irq, 0);
    end
`else
    check(name, irq, 0);
`endif
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{8'h12, 8'd3, 12};
    vecs[1] = '{8'hA5, 8'd0, 4};
    vecs[2] = '{8'h3C, 8'd1, 4};
    vecs[3] = '{8'h7E, 8'd2, 8};
    repeat (3) @(negedge clk);
    check("rst_cmd", ir_cmd, 8'h00);
    check("rst_we", ir_we, 0);
    check("rst_irq", irq, 0);
    status("rst_status", 8'h10);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wr(STAGE, vecs[i].cmd, t);
      wr(PUSH, vecs[i].dur, t);
      sb.push_back(exp_t'{t + 2, vecs[i].cmd});
      sb.push_back(exp_t'{t + 2 + vecs[i].gap, 8'h00});
      repeat (vecs[i].gap + 6) @(negedge clk);
      status("vec_idle_status", 8'h10);
      irq_expect("vec_drain_irq", 1'b1);
    end
    wr(CTRL, 8'h01, t);
    repeat (3) @(negedge clk);
    status("idle_flush_status", 8'h10);
    wr(STAGE, 8'h14, t);
    wr(PUSH, 8'd2, t0);
    sb.push_back(exp_t'{t0 + 2, 8'h14});
    wr(STAGE, 8'h18, t);
    wr(PUSH, 8'd1, t);
    sb.push_back(exp_t'{t0 + 10, 8'h18});
    sb.push_back(exp_t'{t0 + 14, 8'h00});
    status("busy_one_queued", 8'h41);
    repeat (14) @(negedge clk);
    status("pair_idle_status", 8'h10);
    irq_expect("pair_drain_irq", 1'b1);
    wr(STAGE, 8'hA1, t);
    wr(PUSH, 8'd20, t);
    sb.push_back(exp_t'{t + 2, 8'hA1});
    wr(STAGE, 8'h55, t);
    for (int i = 0; i < 9; i++) wr(PUSH, 8'd1, t);
    status("ovf_full_status", 8'hE8);
    wr(CTRL, 8'h02, t);
    status("ovf_cleared_status", 8'h68);
    sb.push_back(exp_t'{cyc + 1, 8'h00});
    wr(CTRL, 8'h01, t);
    status("flush_full_status", 8'h10);
    repeat (10) @(negedge clk);
    irq_expect("flush_full_irq", 1'b0);
    wr(STAGE, 8'h21, t);
    wr(PUSH, 8'd10, t);
    sb.push_back(exp_t'{t + 2, 8'h21});
    wr(STAGE, 8'h22, t);
    for (int i = 0; i < 3; i++) wr(PUSH, 8'd1, t);
    status("three_queued_status", 8'h43);
    sb.push_back(exp_t'{cyc + 1, 8'h00});
    wr(CTRL, 8'h01, t);
    status("flush_mid_status", 8'h10);
    repeat (50) @(negedge clk);
    irq_expect("flush_mid_irq", 1'b0);
    wr(STAGE, 8'h31, t);
    wr(PUSH, 8'd10, t);
    sb.push_back(exp_t'{t + 2, 8'h31});
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("hold_rst_cmd", ir_cmd, 8'h00);
    check("hold_rst_we", ir_we, 0);
    reset = 1'b1;
    status("hold_rst_status", 8'h10);
    repeat (50) @(negedge clk);
    irq_expect("hold_rst_irq", 1'b0);
    wr(PUSH, 8'd1, t);
    sb.push_back(exp_t'{t + 2, 8'h00});
    sb.push_back(exp_t'{t + 6, 8'h00});
    repeat (10) @(negedge clk);
    status("post_rst_status", 8'h10);
    irq_expect("post_rst_irq", 1'b1);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
